axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- AXI4 burst responder that serves cache-line refills and write-backs issued by the core's instruction and data caches.
- Sits at the far end of the memory bus as the memory-side endpoint, backed by an internal word-addressed SRAM array.
- Handles one transaction at a time, read or write, with INCR bursts.
- Out-of-range addresses are answered with SLVERR.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, data beat width; bytes per beat = DATA_WIDTH/8.
- ID_WIDTH, 4, transaction ID width.
- DEPTH_LOG2, 12, log2 of SRAM depth in DATA_WIDTH words.
- BASE_ADDR, 32'h8000_0000, first byte address decoded by the block.
- RD_LATENCY, 2, idle cycles between AR accept and the first R beat; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- awvalid in 1 / awready out 1 / awaddr in ADDR_WIDTH / awlen in 8 / awid in ID_WIDTH  write address channel
- wvalid in 1 / wready out 1 / wdata in DATA_WIDTH / wstrb in DATA_WIDTH/8 / wlast in 1  write data channel
- bvalid out 1 / bready in 1 / bresp out 2 / bid out ID_WIDTH  write response channel
- arvalid in 1 / arready out 1 / araddr in ADDR_WIDTH / arlen in 8 / arid in ID_WIDTH  read address channel
- rvalid out 1 / rready in 1 / rdata out DATA_WIDTH / rresp out 2 / rlast out 1 / rid out ID_WIDTH  read data channel

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: FSM goes to IDLE; all ready/valid outputs 0; rdata, bresp, rresp, bid, rid, rlast all 0; last_grant = WRITE, so the first contended grant goes to read. SRAM contents are not reset.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_RESP.
- IDLE arbitration:
  - Only arvalid set: grant read.
  - Only awvalid set: grant write.
  - Both set: grant the opposite of last_grant.
- Grant action:
  - The granted ready (arready or awready) pulses high for exactly 1 cycle; the other stays 0.
  - Latch addr, len, id; set beat counter = 0; set err = address out of range.
  - Read grant goes to RD_WAIT; write grant goes to WR_BEAT.
- Address range: err = 1 when addr < BASE_ADDR or addr >= BASE_ADDR + (DATA_WIDTH/8 << DEPTH_LOG2). Range is checked on the start address only.
- Beat address: word index = ((addr - BASE_ADDR) >> log2(DATA_WIDTH/8)) + beat, taken modulo 2^DEPTH_LOG2 (wraps). Low address bits are ignored; every beat is a full-width aligned word.
- RD_WAIT: count RD_LATENCY cycles, then go to RD_BEAT.
- RD_BEAT:
  - rvalid = 1; rdata = SRAM[word], or 0 when err; rresp = 2'b10 when err, else 2'b00; rid = latched id; rlast = (beat == len).
  - All R outputs hold stable while rvalid && !rready.
  - On rready: if rlast, go to IDLE, set last_grant = READ, drop rvalid the next cycle. Otherwise beat+1, and the next beat is presented on the following cycle (back-to-back beats allowed, 1 beat/cycle).
- WR_BEAT:
  - wready = 1.
  - On wvalid: write each byte lane whose wstrb bit is 1, only when !err; beat+1.
  - Move to WR_RESP on the beat with wlast = 1, or on the beat where beat == len, whichever comes first. Further W beats are not accepted in this transaction.
  - A wlast/len mismatch forces bresp = 2'b10.
- WR_RESP:
  - bvalid = 1; bid = latched id; bresp = 2'b10 on err or mismatch, else 2'b00.
  - On bready: go to IDLE, set last_grant = WRITE.
- Read-after-write: the SRAM write completes before bvalid, so a read granted after B returns the new data.
- Reset mid-burst: the transaction is abandoned with no response; any partial writes already done remain in the SRAM.

Optional Feature:
- Macro: AXI_SRAM_SLAVE_STAT_EN.
- Defined: adds output ports rd_burst_cnt (64), wr_burst_cnt (64), err_cnt (64), all cleared by rst.
  - rd_burst_cnt increments on each read-grant cycle.
  - wr_burst_cnt increments on each write-grant cycle.
  - err_cnt increments on each grant with err = 1.
- Undefined: these ports and their counters do not exist.

Test Plan:
- Write awaddr=0x8000_0000, awlen=3, beats 0x11..0x44 with wstrb=0xFF, then read the same line with arlen=3 -> B okay, bid matches awid; R returns 0x11,0x22,0x33,0x44, rlast only on beat 3; first rvalid exactly RD_LATENCY+1 cycles after the arready pulse.
- awvalid and arvalid asserted together from reset -> read granted first; the write is granted right after the read's last beat handshake.
- rready toggling 1-0-0-1 during a read burst -> rdata, rlast, rid held stable while stalled; no beat skipped or repeated.
- Write of 0xFFFF_FFFF_FFFF_FFFF with wstrb=0xFF, then 0x0 with wstrb=0x0F, then read -> 0xFFFF_FFFF_0000_0000.
- araddr=0x7FFF_FFF8, arlen=1 -> 2 beats, rresp=2'b10, rdata=0. Write to 0x9000_0000 -> bresp=2'b10 and the SRAM is unchanged.
- Write with awlen=3 but wlast on beat 1 -> only 2 beats accepted, bresp=2'b10. Assert rst mid read burst -> rvalid=0 on the next cycle; FSM in IDLE.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
// Bundles the five AXI4 channels used between a cache-side master and the
// axi_sram_slave memory endpoint.
//   Write address : awvalid, awready, awaddr, awlen, awid
//   Write data    : wvalid, wready, wdata, wstrb, wlast
//   Write response: bvalid, bready, bresp, bid
//   Read address  : arvalid, arready, araddr, arlen, arid
//   Read data     : rvalid, rready, rdata, rresp, rlast, rid
// Modports: master (cache / bench side), slave (memory side).
// ---------------------------------------------------------------------------
interface axi_sram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);

   logic                    awvalid;
   logic                    awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [ID_WIDTH-1:0]     awid;

   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;

   logic                    bvalid;
   logic                    bready;
   logic [1:0]              bresp;
   logic [ID_WIDTH-1:0]     bid;

   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [ID_WIDTH-1:0]     arid;

   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic [ID_WIDTH-1:0]     rid;

   modport master (
      output awvalid, awaddr, awlen, awid,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready,
      output arvalid, araddr, arlen, arid,
      input  arready,
      input  rvalid, rdata, rresp, rlast, rid,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awid,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready,
      input  arvalid, araddr, arlen, arid,
      output arready,
      output rvalid, rdata, rresp, rlast, rid,
      input  rready
   );

endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI4 INCR-burst memory endpoint serving cache refills and write-backs from
// an internal word-addressed SRAM. One transaction (read or write) is in
// flight at a time; start addresses outside the decoded window get SLVERR.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - axi_sram_slave_if.slave (AW, W, B, AR, R channels)
//
// Optional build macro AXI_SRAM_SLAVE_STAT_EN adds 64-bit statistic outputs:
//   rd_burst_cnt - read grants, wr_burst_cnt - write grants,
//   err_cnt      - grants whose start address was out of range.
// ---------------------------------------------------------------------------
module axi_sram_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    ID_WIDTH   = 4,
   parameter int                    DEPTH_LOG2 = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                    RD_LATENCY = 2
) (
   input logic             clk,
   input logic             rst,
   axi_sram_slave_if.slave bus
`ifdef AXI_SRAM_SLAVE_STAT_EN
   ,
   output logic [63:0]     rd_burst_cnt,
   output logic [63:0]     wr_burst_cnt,
   output logic [63:0]     err_cnt
`endif
);

   localparam int BYTES      = DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(BYTES);
   localparam int WORDS      = 1 << DEPTH_LOG2;
   // One bit wider than the address so BASE_ADDR + span cannot overflow.
   localparam logic [ADDR_WIDTH:0] LIMIT =
      {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(BYTES << DEPTH_LOG2);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_RESP} state_t;
   typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

   state_t                  state;
   grant_t                  last_grant;
   logic [7:0]              len;
   logic [7:0]              beat;
   logic [ID_WIDTH-1:0]     id;
   logic                    err;
   logic [DEPTH_LOG2-1:0]   base_word;
   logic [7:0]              wait_cnt;

   logic [DATA_WIDTH-1:0]   mem [WORDS];

   logic                    grant_rd;
   logic                    grant_wr;
   logic [ADDR_WIDTH-1:0]   g_addr;
   logic [7:0]              g_len;
   logic [ID_WIDTH-1:0]     g_id;
   logic                    g_err;
   logic [DEPTH_LOG2-1:0]   g_word;
   logic [DEPTH_LOG2-1:0]   cur_word;
   logic                    beat_is_last;
   logic                    mem_we;

   // Arbitration in IDLE: a lone request wins outright; when both channels
   // ask at once the one that did not go last wins. The granted channel's
   // address fields are decoded here so the FSM can latch them directly.
   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (state == IDLE) begin
         if (bus.arvalid && bus.awvalid) begin
            grant_rd = (last_grant == GRANT_WRITE);
            grant_wr = (last_grant == GRANT_READ);
         end else begin
            grant_rd = bus.arvalid;
            grant_wr = bus.awvalid;
         end
      end
      g_addr = grant_rd ? bus.araddr : bus.awaddr;
      g_len  = grant_rd ? bus.arlen  : bus.awlen;
      g_id   = grant_rd ? bus.arid   : bus.awid;
      g_err  = ({1'b0, g_addr} < {1'b0, BASE_ADDR}) || ({1'b0, g_addr} >= LIMIT);
      // Sub-word address bits are dropped; bits above the SRAM depth wrap.
      g_word = DEPTH_LOG2'((g_addr - BASE_ADDR) >> BYTE_SHIFT);
   end

   // Current beat's SRAM word; wraps naturally at the top of the array.
   assign cur_word     = base_word + DEPTH_LOG2'(beat);
   assign beat_is_last = (beat == len);
   assign mem_we       = !rst && (state == WR_BEAT) && bus.wvalid && !err;

   // Byte-lane SRAM write. Error transactions never touch the array, and the
   // write lands during WR_BEAT so it is visible before bvalid rises.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (bus.wstrb[i]) begin
               mem[cur_word][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

   // Main transaction FSM with all channel outputs registered. Read data is
   // fetched one cycle ahead of presentation: on leaving RD_WAIT for beat 0,
   // and on each R handshake for the following beat, so bursts stream at one
   // beat per cycle while rready stays high and hold still while it is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= GRANT_WRITE;
         len         <= '0;
         beat        <= '0;
         id          <= '0;
         err         <= 1'b0;
         base_word   <= '0;
         wait_cnt    <= '0;
         bus.arready <= 1'b0;
         bus.awready <= 1'b0;
         bus.wready  <= 1'b0;
         bus.bvalid  <= 1'b0;
         bus.bresp   <= 2'b00;
         bus.bid     <= '0;
         bus.rvalid  <= 1'b0;
         bus.rdata   <= '0;
         bus.rresp   <= 2'b00;
         bus.rlast   <= 1'b0;
         bus.rid     <= '0;
      end else begin
         bus.arready <= 1'b0;
         bus.awready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_rd || grant_wr) begin
                  len       <= g_len;
                  id        <= g_id;
                  err       <= g_err;
                  base_word <= g_word;
                  beat      <= '0;
                  wait_cnt  <= '0;
                  if (grant_rd) begin
                     bus.arready <= 1'b1;
                     state       <= RD_WAIT;
                  end else begin
                     bus.awready <= 1'b1;
                     bus.wready  <= 1'b1;
                     state       <= WR_BEAT;
                  end
               end
            end
            RD_WAIT: begin
               // The arready cycle counts as wait_cnt 0, leaving RD_LATENCY
               // empty cycles before the first beat appears.
               if (wait_cnt == 8'(RD_LATENCY)) begin
                  state      <= RD_BEAT;
                  bus.rvalid <= 1'b1;
                  bus.rdata  <= err ? '0 : mem[cur_word];
                  bus.rresp  <= err ? 2'b10 : 2'b00;
                  bus.rid    <= id;
                  bus.rlast  <= beat_is_last;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RD_BEAT: begin
               if (bus.rready) begin
                  if (beat_is_last) begin
                     bus.rvalid <= 1'b0;
                     bus.rlast  <= 1'b0;
                     last_grant <= GRANT_READ;
                     state      <= IDLE;
                  end else begin
                     beat      <= beat + 8'd1;
                     bus.rdata <= err ? '0 : mem[cur_word + DEPTH_LOG2'(1)];
                     bus.rlast <= ((beat + 8'd1) == len);
                  end
               end
            end
            WR_BEAT: begin
               // The burst closes on wlast or on the len-th beat, whichever
               // arrives first; disagreement between the two is an error.
               if (bus.wvalid) begin
                  beat <= beat + 8'd1;
                  if (bus.wlast || beat_is_last) begin
                     bus.wready <= 1'b0;
                     bus.bvalid <= 1'b1;
                     bus.bid    <= id;
                     bus.bresp  <= (err || (bus.wlast != beat_is_last)) ? 2'b10 : 2'b00;
                     state      <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (bus.bready) begin
                  bus.bvalid <= 1'b0;
                  last_grant <= GRANT_WRITE;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXI_SRAM_SLAVE_STAT_EN
   // Statistic counters advance on the grant decision cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_burst_cnt <= '0;
         wr_burst_cnt <= '0;
         err_cnt      <= '0;
      end else begin
         if (grant_rd) begin
            rd_burst_cnt <= rd_burst_cnt + 64'd1;
         end
         if (grant_wr) begin
            wr_burst_cnt <= wr_burst_cnt + 64'd1;
         end
         if ((grant_rd || grant_wr) && g_err) begin
            err_cnt <= err_cnt + 64'd1;
         end
      end
   end
`endif

endmodule
